simplebus_pkt_gate: RTL
=======================

// Module: simplebus_pkt_gate
// PURPOSE
// - SimpleBus-configured byte-stream gate: consumes rxd/rx_dv frames, forwards or drops
//   whole frames, optionally XOR-masks bytes, drives txd/tx_en after a fixed latency.
// - Hosts a small SimpleBus register slave (control, mask, frame/byte counters).
// - Sits directly downstream of the bus/stream driver clocking blocks; its outputs feed the output monitor.
// PARAMETERS
// - LAT       2   datapath latency in cycles, rxd/rx_dv -> txd/tx_en; legal 1..8
// - CNT_W     16  counter width; must be <= 16
// PORTS
// - clk            in   1   single clock, all logic on posedge
// - rst_n          in   1   reset, asynchronous, active-low
// - bus_cmd_valid  in   1   bus command strobe, one command per high cycle
// - bus_op         in   1   1 = write, 0 = read
// - bus_addr       in   16  register address
// - bus_wr_data    in   16  write data
// - bus_rd_data    out  16  read data, registered
// - rxd            in   8   input byte
// - rx_dv          in   1   input byte valid; a frame is a maximal run of rx_dv=1
// - txd            out  8   output byte
// - tx_en          out  1   output byte valid
// BEHAVIOUR
// - Reset, async: txd=0, tx_en=0, bus_rd_data=0, FSM=IDLE, pipeline cleared.
//   Registers: CTRL=0x0001, MASK=0x00, counters=0. rx_dv_q resets to 1.
// - Register map. Unmapped reads return 0; unmapped writes are ignored.
//   0x0000 CTRL      RW  [0] pass_en, [1] xor_en, others read 0
//   0x0001 MASK      RW  [7:0] xor mask, [15:8] read 0
//   0x0002 FRM_CNT   RO  forwarded frames; any write clears it
//   0x0003 BYTE_CNT  RO  forwarded bytes; any write clears it
// - Bus timing: a read with cmd_valid=1 at edge N drives bus_rd_data at N+1.
//   bus_rd_data holds that value for one cycle, then returns to 0.
// - Bus writes update the register at the same edge. The new value is visible to a read at N+1.
// - Frame start: rx_dv=1 while rx_dv_q=0.
//   Because rx_dv_q resets to 1, a frame already in progress when reset is released is
//   ignored until rx_dv drops.
// - FSM:
//   IDLE -> FWD on frame start when pass_en=1; DROP on frame start when pass_en=0.
//   FWD/DROP -> IDLE on rx_dv=0.
//   A one-cycle rx_dv gap ends a frame; the next cycle may start a new one.
// - At frame start, pass_en, xor_en and MASK are snapshotted. Changes mid-frame apply only
//   from the next frame start. A write landing on the start edge is not seen: the old value is used.
// - Datapath, per byte with rx_dv=1 in FWD (including the start byte):
//   d = xor_en_s ? rxd ^ mask_s : rxd.
//   d and valid go through an LAT-stage shift register to txd/tx_en.
//   Non-forwarded cycles insert tx_en=0, txd=0.
// - Counters:
//   BYTE_CNT +1 per forwarded byte.
//   FRM_CNT +1 on the FWD->IDLE transition.
//   Both wrap modulo 2^CNT_W.
//   A write-clear in the same cycle as an increment wins: result is 0.
// - Async reset mid-frame: outputs drop to 0 immediately and in-flight pipeline bytes are lost.
// TESTING
// - Default config, 4-byte frame 11 22 33 44 -> same bytes on txd, tx_en=1 for 4 cycles
//   starting LAT cycles later; FRM_CNT=1, BYTE_CNT=4.
// - Write CTRL=0x0003, MASK=0x00FF; frame 0x0F 0xA5 -> txd 0xF0 0x5A.
//   Read 0x0001 -> 0x00FF the next cycle.
// - Write CTRL=0x0000 in the middle of a forwarded frame -> that frame completes intact.
//   The next frame is dropped (tx_en stays 0) and FRM_CNT is unchanged.
// - Reset released while rx_dv=1 -> nothing forwarded. The next frame after a gap is forwarded.
// - Preload BYTE_CNT=0xFFFF via 0xFFFF bytes, then 1 more byte -> 0x0000.
//   A write to 0x0003 on an increment cycle -> reads 0.
// - Two frames separated by one idle cycle -> two frames out with one-cycle tx_en gap;
//   FRM_CNT=2. A read of 0x0010 returns 0.

Source files
------------

// File: rtl/simplebus_pkt_gate_if.sv
// SimpleBus register-access interface for simplebus_pkt_gate.
// Carries the one-cycle command strobe, the write/read select, the address,
// the write data and the registered read data.
//   master : drives bus_cmd_valid/bus_op/bus_addr/bus_wr_data, samples bus_rd_data
//   slave  : samples the command signals, drives bus_rd_data
interface simplebus_pkt_gate_if;
  logic        bus_cmd_valid;
  logic        bus_op;
  logic [15:0] bus_addr;
  logic [15:0] bus_wr_data;
  logic [15:0] bus_rd_data;

  modport master (
    output bus_cmd_valid,
    output bus_op,
    output bus_addr,
    output bus_wr_data,
    input  bus_rd_data
  );

  modport slave (
    input  bus_cmd_valid,
    input  bus_op,
    input  bus_addr,
    input  bus_wr_data,
    output bus_rd_data
  );
endinterface

// File: rtl/simplebus_pkt_gate.sv
// Byte-stream frame gate with a SimpleBus register slave.
// Frames (maximal runs of rx_dv=1) are either forwarded whole or dropped
// whole, depending on pass_en sampled at the frame's first byte. Forwarded
// bytes are optionally XOR-masked and appear on txd/tx_en LAT cycles later.
// Ports:
//   clk    - clock, everything on posedge
//   rst_n  - asynchronous active-low reset
//   bus    - SimpleBus slave: CTRL(0x0) MASK(0x1) FRM_CNT(0x2) BYTE_CNT(0x3)
//   rxd    - input byte
//   rx_dv  - input byte valid
//   txd    - output byte (0 when not valid)
//   tx_en  - output byte valid
module simplebus_pkt_gate #(
  parameter int LAT   = 2,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  simplebus_pkt_gate_if.slave         bus,
  input  logic [7:0]                  rxd,
  input  logic                        rx_dv,
  output logic [7:0]                  txd,
  output logic                        tx_en
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t state, state_next;

  // Configuration registers
  logic       pass_en;
  logic       xor_en;
  logic [7:0] mask;

  // Per-frame snapshot of the masking configuration
  logic       xor_s;
  logic [7:0] mask_s;

  logic [CNT_W-1:0] frm_cnt;
  logic [CNT_W-1:0] byte_cnt;

  // rx_dv_q resets to 1 so a frame already running at reset release is not
  // mistaken for a frame start.
  logic rx_dv_q;

  logic       frame_start;
  logic       fwd_byte;
  logic       frame_done;
  logic       xor_eff;
  logic [7:0] mask_eff;
  logic [7:0] d_in;

  logic        wr_en;
  logic        rd_en;
  logic [15:0] rd_mux;

  logic [7:0] pipe_d [LAT];
  logic       pipe_v [LAT];

  // Upper write-data bits have no register backing.
  logic unused_wr_bits;
  assign unused_wr_bits = &{1'b0, bus.bus_wr_data[15:8]};

  assign wr_en = bus.bus_cmd_valid &  bus.bus_op;
  assign rd_en = bus.bus_cmd_valid & ~bus.bus_op;

  assign frame_start = rx_dv & ~rx_dv_q;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    fwd_byte   = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          state_next = pass_en ? FWD : DROP;
          fwd_byte   = pass_en;
        end
      end
      FWD: begin
        if (rx_dv) begin
          fwd_byte = 1'b1;
        end else begin
          state_next = IDLE;
          frame_done = 1'b1;
        end
      end
      DROP: begin
        if (!rx_dv) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The start byte uses the live register values (the snapshot is only
  // captured at that same edge); later bytes use the snapshot.
  always_comb begin
    xor_eff  = frame_start ? xor_en : xor_s;
    mask_eff = frame_start ? mask   : mask_s;
    d_in     = 8'h00;
    if (fwd_byte) begin
      d_in = xor_eff ? (rxd ^ mask_eff) : rxd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_dv_q <= 1'b1;
      xor_s   <= 1'b0;
      mask_s  <= 8'h00;
    end else begin
      rx_dv_q <= rx_dv;
      if (frame_start) begin
        xor_s  <= xor_en;
        mask_s <= mask;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output pipeline: LAT stages, stage LAT-1 drives the outputs
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < LAT; gi++) begin : g_pipe
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe_d[gi] <= 8'h00;
        pipe_v[gi] <= 1'b0;
      end else if (gi == 0) begin
        pipe_d[gi] <= d_in;
        pipe_v[gi] <= fwd_byte;
      end else begin
        pipe_d[gi] <= pipe_d[(gi == 0) ? 0 : gi - 1];
        pipe_v[gi] <= pipe_v[(gi == 0) ? 0 : gi - 1];
      end
    end
  end

  assign txd   = pipe_d[LAT-1];
  assign tx_en = pipe_v[LAT-1];

  // ---------------------------------------------------------------------------
  // Register file and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_en <= 1'b1;
      xor_en  <= 1'b0;
      mask    <= 8'h00;
    end else if (wr_en) begin
      case (bus.bus_addr)
        16'h0000: begin
          pass_en <= bus.bus_wr_data[0];
          xor_en  <= bus.bus_wr_data[1];
        end
        16'h0001: mask <= bus.bus_wr_data[7:0];
        default: ;
      endcase
    end
  end

  // A clearing write takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt  <= '0;
      byte_cnt <= '0;
    end else begin
      if (wr_en && bus.bus_addr == 16'h0002) begin
        frm_cnt <= '0;
      end else if (frame_done) begin
        frm_cnt <= frm_cnt + CNT_W'(1);
      end
      if (wr_en && bus.bus_addr == 16'h0003) begin
        byte_cnt <= '0;
      end else if (fwd_byte) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rd_mux = 16'h0000;
    case (bus.bus_addr)
      16'h0000: rd_mux = {14'h0000, xor_en, pass_en};
      16'h0001: rd_mux = {8'h00, mask};
      16'h0002: rd_mux = 16'(frm_cnt);
      16'h0003: rd_mux = 16'(byte_cnt);
      default:  rd_mux = 16'h0000;
    endcase
  end

  // Read data is valid for exactly the cycle after the read command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.bus_rd_data <= 16'h0000;
    end else begin
      bus.bus_rd_data <= rd_en ? rd_mux : 16'h0000;
    end
  end

endmodule
